// File: rtl/imem_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_load_sequencer_pkg
// Desc   : Shared state encoding, error codes and default widths.
// Rev    : 1.0
// ============================================================================
package imem_load_sequencer_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_ARM  = 3'd2,
      ST_EXEC = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } seq_state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_EMPTY   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/imem_load_sequencer_exec_watchdog.sv
`default_nettype none
// ============================================================================
// Module : imem_load_sequencer_exec_watchdog
// Desc   : 16-bit execution cycle counter with terminal-count flag.
// Rev    : 1.0
// ============================================================================
module imem_load_sequencer_exec_watchdog #(
   parameter int TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_clr,
   input  logic        i_en,
   output logic [15:0] o_count,
   output logic        o_tc
);

   localparam logic [15:0] c_TERMINAL = 16'(TIMEOUT - 1);

   logic [15:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count = r_count;
   assign o_tc    = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/imem_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module : imem_load_sequencer
// Desc   : Streams a host program into instruction memory, then runs the core.
// Rev    : 1.0
// ============================================================================
module imem_load_sequencer
   import imem_load_sequencer_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DEPTH   = 2 ** ADDR_W,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              host_valid,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ready,
   input  logic              exec_start,
   input  logic              core_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_reset,
   output logic              core_run,
   output logic              busy,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   loaded_count,
   output logic [15:0]       cycle_count
);

   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] c_ONE   = (ADDR_W + 1)'(1);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   w_len_nxt;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] w_wr_ptr_nxt;
   logic [ADDR_W:0]   r_loaded_count;
   logic [ADDR_W:0]   w_loaded_count_nxt;
   logic [1:0]        r_err_code;
   logic [1:0]        w_err_code_nxt;

   logic              w_beat;
   logic              w_last_beat;
   logic              w_len_bad;
   logic              w_wd_clr;
   logic              w_wd_en;
   logic              w_wd_tc;

   assign w_beat      = (r_state == ST_LOAD) && host_valid;
   assign w_last_beat = ({1'b0, r_wr_ptr} == (r_len - c_ONE));
   assign w_len_bad   = (load_len == '0) || (load_len > c_DEPTH);
   assign w_wd_en     = (r_state == ST_EXEC);

   imem_load_sequencer_exec_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_wd_clr),
      .i_en    (w_wd_en),
      .o_count (cycle_count),
      .o_tc    (w_wd_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_len          <= '0;
         r_wr_ptr       <= '0;
         r_loaded_count <= '0;
         r_err_code     <= ERR_NONE;
      end else begin
         r_state        <= w_state_nxt;
         r_len          <= w_len_nxt;
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_loaded_count <= w_loaded_count_nxt;
         r_err_code     <= w_err_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_len_nxt          = r_len;
      w_wr_ptr_nxt       = r_wr_ptr;
      w_loaded_count_nxt = r_loaded_count;
      w_err_code_nxt     = r_err_code;
      w_wd_clr           = 1'b0;

      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // load_start takes priority over exec_start
            if (load_start) begin
               if (w_len_bad) begin
                  w_state_nxt    = ST_ERR;
                  w_err_code_nxt = ERR_LEN;
               end else begin
                  w_state_nxt        = ST_LOAD;
                  w_len_nxt          = load_len;
                  w_wr_ptr_nxt       = '0;
                  w_loaded_count_nxt = '0;
                  w_err_code_nxt     = ERR_NONE;
               end
            end else if (exec_start) begin
               if (r_loaded_count == '0) begin
                  w_state_nxt    = ST_ERR;
                  w_err_code_nxt = ERR_EMPTY;
               end else begin
                  w_state_nxt    = ST_ARM;
                  w_wd_clr       = 1'b1;
                  w_err_code_nxt = ERR_NONE;
               end
            end
         end

         ST_LOAD: begin
            if (w_beat) begin
               w_wr_ptr_nxt = r_wr_ptr + 1'b1;
               if (w_last_beat) begin
                  w_state_nxt        = ST_IDLE;
                  w_loaded_count_nxt = r_len;
               end
            end
         end

         ST_ARM: begin
            w_state_nxt = ST_EXEC;
         end

         ST_EXEC: begin
            if (core_done) begin
               w_state_nxt = ST_DONE;
            end else if (w_wd_tc) begin
               w_state_nxt    = ST_ERR;
               w_err_code_nxt = ERR_TIMEOUT;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign mem_we    = w_beat;
   assign mem_addr  = w_beat ? r_wr_ptr  : '0;
   assign mem_wdata = w_beat ? host_data : '0;

   assign host_ready   = (r_state == ST_LOAD);
   assign core_run     = (r_state == ST_EXEC);
   // DONE keeps the core out of reset so its final state can be inspected
   assign core_reset   = !((r_state == ST_EXEC) || (r_state == ST_DONE));
   assign busy         = (r_state == ST_LOAD) || (r_state == ST_ARM) || (r_state == ST_EXEC);
   assign err          = (r_state == ST_ERR);
   assign err_code     = r_err_code;
   assign loaded_count = r_loaded_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_imem_load_sequencer
// Desc   : Random load/exec sequences scored against a command-level model.
// Rev    : 1.0
// ============================================================================
module tb_imem_load_sequencer;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int DEPTH   = 256;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              load_start = 1'b0;
   logic [ADDR_W:0]   load_len = '0;
   logic              host_valid = 1'b0;
   logic [DATA_W-1:0] host_data = '0;
   logic              host_ready;
   logic              exec_start = 1'b0;
   logic              core_done = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              core_reset;
   logic              core_run;
   logic              busy;
   logic              err;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   loaded_count;
   logic [15:0]       cycle_count;

   always #5 clk = ~clk;

   imem_load_sequencer #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_start   (load_start),
      .load_len     (load_len),
      .host_valid   (host_valid),
      .host_data    (host_data),
      .host_ready   (host_ready),
      .exec_start   (exec_start),
      .core_done    (core_done),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_reset   (core_reset),
      .core_run     (core_run),
      .busy         (busy),
      .err          (err),
      .err_code     (err_code),
      .loaded_count (loaded_count),
      .cycle_count  (cycle_count)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  run_total = 0;
   wr_t q_exp[$];
   logic [DATA_W-1:0] wbuf [DEPTH];

   // Model: 0 idle, 1 done, 2 error
   int m_st, m_loaded, m_code, m_cycle;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every memory write must match the next expected word
   always @(negedge clk) begin
      wr_t e;
      if (core_run === 1'b1) run_total++;
      if (mem_we !== 1'b0) begin
         if (q_exp.size() == 0) begin
            check("unexpected_write", {31'd0, mem_we}, 32'd0);
         end else begin
            e = q_exp.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.a));
            check("wr_data", 32'(mem_wdata), 32'(e.d));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      @(negedge clk);
      check({tag, "_busy"},       32'(busy),         32'd0);
      check({tag, "_err"},        32'(err),          32'(m_st == 2));
      check({tag, "_err_code"},   32'(err_code),     32'(m_code));
      check({tag, "_loaded"},     32'(loaded_count), 32'(m_loaded));
      check({tag, "_core_reset"}, 32'(core_reset),   32'(m_st != 1));
      check({tag, "_core_run"},   32'(core_run),     32'd0);
      check({tag, "_host_ready"}, 32'(host_ready),   32'd0);
      check({tag, "_cycles"},     32'(cycle_count),  32'(m_cycle));
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; load_start = 1'b0; exec_start = 1'b0;
      host_valid = 1'b0; core_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      m_st = 0; m_loaded = 0; m_code = 0; m_cycle = 0;
      q_exp.delete();
   endtask

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) wbuf[i] = DATA_W'($urandom);
   endtask

   // gap_mode: 0 back-to-back, 1 idle cycle between words, 2 random idles
   task automatic do_load(input int len, input bit also_exec, input int gap_mode);
      load_start = 1'b1;
      load_len   = (ADDR_W + 1)'(len);
      exec_start = also_exec;
      tick();
      load_start = 1'b0;
      exec_start = 1'b0;
      load_len   = (ADDR_W + 1)'($urandom);
      if (len < 1 || len > DEPTH) begin
         m_st = 2; m_code = 1;
         check_status("badlen");
         return;
      end
      for (int i = 0; i < len; i++) begin
         if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            host_valid = 1'b0;
            host_data  = DATA_W'($urandom);
            exec_start = 1'($urandom);
            core_done  = 1'($urandom);
            @(negedge clk);
            check("gap_ready", 32'(host_ready), 32'd1);
            @(posedge clk);
            #1;
         end
         host_valid = 1'b1;
         host_data  = wbuf[i];
         exec_start = 1'($urandom);
         core_done  = 1'($urandom);
         q_exp.push_back(wr_t'{a: ADDR_W'(i), d: wbuf[i]});
         @(negedge clk);
         check("load_ready", 32'(host_ready), 32'd1);
         check("load_core_reset", 32'(core_reset), 32'd1);
         @(posedge clk);
         #1;
      end
      host_valid = 1'b0; exec_start = 1'b0; core_done = 1'b0;
      m_st = 0; m_loaded = len; m_code = 0;
      check("wr_pending", 32'(q_exp.size()), 32'd0);
      check_status("load");
   endtask

   // k: core_done raised in the k-th EXEC cycle; k = 0 means never
   task automatic do_exec(input int k);
      int n, r0;
      exec_start = 1'b1;
      tick();
      exec_start = 1'b0;
      if (m_loaded == 0) begin
         m_st = 2; m_code = 2;
         check_status("empty");
         return;
      end
      @(negedge clk);
      check("arm_core_reset", 32'(core_reset), 32'd1);
      check("arm_core_run",   32'(core_run),   32'd0);
      check("arm_busy",       32'(busy),       32'd1);
      @(posedge clk);
      #1;
      r0 = run_total;
      n = (k > 0 && k < TIMEOUT) ? k : TIMEOUT;
      for (int c = 1; c <= n; c++) begin
         core_done = (c == k);
         tick();
      end
      core_done = 1'b0;
      m_cycle = n;
      if (k >= 1 && k <= TIMEOUT) begin
         m_st = 1; m_code = 0;
      end else begin
         m_st = 2; m_code = 3;
      end
      check("run_cycles", 32'(run_total - r0), 32'(n));
      check_status("exec");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int op, len;
      do_reset();
      @(negedge clk);
      check("rst_mem_we",    32'(mem_we),    32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk);
      #1;
      check_status("reset");

      do_exec(5);

      wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC;
      do_load(3, 1'b0, 0);

      fill_random(2);
      do_load(2, 1'b0, 1);
      do_exec(5);
      do_exec(0);

      do_load(0, 1'b0, 0);
      fill_random(2);
      do_load(2, 1'b1, 0);
      do_exec(TIMEOUT);
      do_exec(TIMEOUT + 1);

      do_load(257, 1'b0, 0);
      do_load(300, 1'b0, 0);
      fill_random(DEPTH);
      do_load(DEPTH, 1'b0, 0);
      do_exec(1);

      // Reset in the middle of a 4-word load
      load_start = 1'b1; load_len = 9'd4;
      tick();
      load_start = 1'b0;
      wbuf[0] = 16'hBEEF;
      host_valid = 1'b1; host_data = wbuf[0];
      q_exp.push_back(wr_t'{a: '0, d: wbuf[0]});
      tick();
      host_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      m_st = 0; m_loaded = 0; m_code = 0; m_cycle = 0;
      check_status("midload_reset");
      do_exec(3);

      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         if (op < 2) begin
            if ($urandom_range(0, 9) == 0)
               len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
            else
               len = $urandom_range(1, 16);
            fill_random(16);
            do_load(len, 1'($urandom), 2);
         end else begin
            do_exec($urandom_range(0, TIMEOUT + 3));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/imem_load_sequencer.md
Name: imem_load_sequencer

Overview:
Top-level controller that owns the instruction-memory write port and the core's run/reset lines.
- Streams a program from a host valid/ready interface into instruction memory, word by word from address 0.
- Then releases the core (fetch unit + datapath) to execute from PC 0.
- Stops on core_done or on a watchdog timeout, and reports status.
- Sits between the host/test harness and the fetch unit's we/value_to_memory/run/reset inputs.

Parameters:
ADDR_W, 8, instruction memory address width
DATA_W, 16, instruction word width
DEPTH, 256, number of memory words (2**ADDR_W)
TIMEOUT, 1000, max EXEC cycles before a watchdog error (must be ≥2, ≤65535)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
load_start  in  1  request to load a program; sampled in IDLE/DONE/ERR only
load_len  in  ADDR_W+1  number of words to load; valid range 1..DEPTH
host_valid  in  1  host word valid
host_data  in  DATA_W  host instruction word
host_ready  out  1  sequencer accepts host word
exec_start  in  1  request to run the loaded program
core_done  in  1  core signals program end
mem_we  out  1  instruction memory write enable
mem_addr  out  ADDR_W  instruction memory write address
mem_wdata  out  DATA_W  instruction memory write data
core_reset  out  1  holds fetch unit/PC in reset
core_run  out  1  run enable to the fetch unit
busy  out  1  high in LOAD, ARM, EXEC
err  out  1  high in ERR
err_code  out  2  0 none, 1 bad length, 2 exec with nothing loaded, 3 timeout
loaded_count  out  ADDR_W+1  words in the last completed load
cycle_count  out  16  EXEC cycles in the current or last run

Behaviour:
- Reset values: state IDLE, host_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, core_run 0, busy 0, err 0, err_code 0, loaded_count 0, cycle_count 0, wr_ptr 0.
- Reset mid-operation (any state) returns to IDLE on the next edge with all values above. The memory contents are not cleared.
- States: IDLE, LOAD, ARM, EXEC, DONE, ERR. All outputs decode from registered state except mem_we, mem_addr and mem_wdata, which are combinational.
- IDLE, DONE and ERR accept commands identically. If load_start and exec_start are both asserted, load_start wins.
  - load_start with 1 ≤ load_len ≤ DEPTH → LOAD. wr_ptr=0, len latched, err cleared, loaded_count=0.
  - load_start with load_len=0 or load_len>DEPTH → ERR, err_code=1.
  - exec_start with loaded_count=0 → ERR, err_code=2.
  - exec_start with loaded_count>0 → ARM, cycle_count=0, err cleared.
- Commands are ignored in LOAD, ARM and EXEC.
- LOAD:
  - host_ready=1, core_reset=1, core_run=0.
  - A beat is host_valid & host_ready. On a beat: mem_we=1, mem_addr=wr_ptr, mem_wdata=host_data in the same cycle; wr_ptr increments on the edge.
  - On the beat where wr_ptr=len-1: → IDLE, loaded_count=len, and host_ready is 0 on the following cycle.
  - Outside a beat: mem_we=0, mem_addr=0, mem_wdata=0.
  - load_len=DEPTH writes addresses 0..DEPTH-1; wr_ptr never wraps within a load.
- ARM: exactly 1 cycle. core_reset=1, core_run=0, so the PC is cleared → EXEC.
- EXEC:
  - core_reset=0, core_run=1. cycle_count increments every cycle.
  - core_done=1 → DONE, and cycle_count includes that cycle.
  - Otherwise, when cycle_count reaches TIMEOUT-1 → ERR, err_code=3.
  - core_done on the timeout cycle: DONE wins.
- DONE: core_run=0, core_reset=0, so core state stays observable. cycle_count is held.
- ERR: core_run=0, core_reset=1. err and err_code are held until a valid command or reset.
- core_done outside EXEC is ignored. host_valid outside LOAD is ignored (host_ready=0).

Decomposition:
- Shared package: state enum (6 states, 3 bits), err_code constants (ERR_NONE, ERR_LEN, ERR_EMPTY, ERR_TIMEOUT), default ADDR_W/DATA_W.
- One sub-module: exec_watchdog. A 16-bit counter with clear, enable and a parameterised terminal-count flag at TIMEOUT-1. It drives cycle_count and the timeout condition.

Test Plan:
- Load 3 words 0x1234/0x5678/0x9ABC with host_valid continuous → mem_we high 3 cycles, addr 0,1,2. host_ready=0 from cycle 4. loaded_count=3, state IDLE.
- Load 2 words with host_valid toggling 1,0,1 → writes only on valid cycles (addr 0 then 1); load completes after the 2nd beat.
- After loading 2 words, pulse exec_start; core_done asserted 5 cycles after core_run rises → 1 ARM cycle with core_reset=1, then core_run=1 for 5 cycles, DONE, cycle_count=5.
- TIMEOUT=8, exec with core_done never asserted → core_run high exactly 8 cycles, then err=1, err_code=3, core_reset=1.
- load_len=0 → ERR code 1. From reset, exec_start → ERR code 2. load_start and exec_start in the same cycle → LOAD.
- Reset asserted mid-LOAD after 1 beat of a 4-word load → next cycle IDLE, host_ready=0, loaded_count=0. exec_start then → ERR code 2.
